// File: rtl/nn_cost_array_if.sv
// rtl/nn_cost_array_if.sv - sample/result/batch-cost bus of the cost-derivative unit
interface nn_cost_array_if #(
  parameter int NB   = 16,
  parameter int NK   = 4,
  parameter int ACCW = 32
);
  logic [NK*NB-1:0] yk;
  logic [NK*NB-1:0] ak;
  logic             in_valid;
  logic             in_ready;
  logic [NK*NB-1:0] epsD;
  logic [NK-1:0]    SIGN;
  logic             out_valid;
  logic             out_ready;
  logic [ACCW-1:0]  cost_sum;
  logic             cost_valid;

  modport master (
    output yk, ak, in_valid, out_ready,
    input  in_ready, epsD, SIGN, out_valid, cost_sum, cost_valid
  );

  modport slave (
    input  yk, ak, in_valid, out_ready,
    output in_ready, epsD, SIGN, out_valid, cost_sum, cost_valid
  );
endinterface

// File: rtl/nn_cost_array.sv
// rtl/nn_cost_array.sv - per-node |ak-yk| and sign via one shared subtractor, plus
// saturating L1 batch cost
module nn_cost_array #(
  parameter int NB       = 16,
  parameter int NK       = 4,
  parameter int NSAMP    = 8,
  parameter int ACCW     = 32,
  parameter int DEADBAND = 0
) (
  input logic          CLK,
  input logic          INIT,
  nn_cost_array_if.slave bus
);

  localparam int KW  = (NK > 1) ? $clog2(NK) : 1;
  localparam int CW  = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam int DBW = NB + 1;
  localparam logic [DBW-1:0] DB     = DBW'(DEADBAND);
  localparam logic [KW-1:0]  K_LAST = KW'(NK - 1);
  localparam logic [CW-1:0]  C_LAST = CW'(NSAMP - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [CW-1:0]    count;
  logic [ACCW-1:0]  acc;
  logic [NB-1:0]    y_w [NK];
  logic [NB-1:0]    a_w [NK];
  logic [NB-1:0]    d_w [NK];
  logic [NK-1:0]    s_w;
  logic [NK*NB-1:0] d_pack;
  logic [NK*NB-1:0] eps_q;
  logic [NK-1:0]    sign_q;
  logic             out_valid_q;
  logic [ACCW-1:0]  cost_q;
  logic             cost_valid_q;

  logic [NB-1:0]    a_cur;
  logic [NB-1:0]    y_cur;
  logic             gt;
  logic [NB-1:0]    diff;
  logic [NB-1:0]    d_eff;
  logic             s_eff;
  logic [ACCW:0]    acc_sum;
  logic [ACCW-1:0]  acc_next;
  logic             accept;
  logic             handshake;

  assign accept    = (state == S_IDLE) && bus.in_valid;
  assign handshake = (state == S_DONE) && out_valid_q && bus.out_ready;

  // Shared channel datapath: one |a-y| per SCAN cycle, selected by k
  assign a_cur = a_w[k];
  assign y_cur = y_w[k];
  assign gt    = a_cur > y_cur;
  assign diff  = gt ? (a_cur - y_cur) : (y_cur - a_cur);

  always_comb begin
    d_eff = diff;
    s_eff = gt;
    if ((DEADBAND != 0) && ({1'b0, diff} < DB)) begin
      d_eff = '0;
      s_eff = 1'b0;
    end
  end

  assign acc_sum  = {1'b0, acc} + {{(ACCW + 1 - NB){1'b0}}, d_eff};
  assign acc_next = acc_sum[ACCW] ? {ACCW{1'b1}} : acc_sum[ACCW-1:0];

  always_comb begin
    d_pack = '0;
    for (int i = 0; i < NK; i++) begin
      d_pack[i*NB +: NB] = d_w[i];
    end
  end

  // Working slots carry no reset: they are always rewritten before being published
  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int i = 0; i < NK; i++) begin
        y_w[i] <= bus.yk[i*NB +: NB];
        a_w[i] <= bus.ak[i*NB +: NB];
      end
    end
    if (state == S_SCAN) begin
      d_w[k] <= d_eff;
      s_w[k] <= s_eff;
    end
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      state        <= S_IDLE;
      k            <= '0;
      count        <= '0;
      acc          <= '0;
      eps_q        <= '0;
      sign_q       <= '0;
      out_valid_q  <= 1'b0;
      cost_q       <= '0;
      cost_valid_q <= 1'b0;
    end else begin
      cost_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            k     <= '0;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          acc <= acc_next;
          if (k == K_LAST) begin
            state <= S_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DONE: begin
          // First DONE cycle publishes the slots; the last slot lands on the SCAN->DONE edge
          if (!out_valid_q) begin
            eps_q       <= d_pack;
            sign_q      <= s_w;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
            if (count == C_LAST) begin
              cost_q       <= acc;
              cost_valid_q <= 1'b1;
              acc          <= '0;
              count        <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.epsD       = eps_q;
  assign bus.SIGN       = sign_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.cost_sum   = cost_q;
  assign bus.cost_valid = cost_valid_q;

  logic unused_ok;
  assign unused_ok = handshake;

endmodule

// File: tb/tb_nn_cost_array.sv
// tb/tb_nn_cost_array.sv - two builds (ACCW=10/DB=0, ACCW=8/DB=3) driven in lockstep
// and checked every cycle against a transaction-level model
module tb_nn_cost_array;
  localparam int NB = 8;
  localparam int NK = 4;
  localparam int NSAMP = 2;

  logic clk = 1'b0;
  logic init = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] yk_v = '0;
  logic [31:0] ak_v = '0;
  logic        in_valid_v = 1'b0;
  logic        out_ready_v = 1'b0;

  nn_cost_array_if #(.NB(NB), .NK(NK), .ACCW(10)) bus0 ();
  nn_cost_array_if #(.NB(NB), .NK(NK), .ACCW(8))  bus1 ();

  assign bus0.yk = yk_v;
  assign bus0.ak = ak_v;
  assign bus0.in_valid = in_valid_v;
  assign bus0.out_ready = out_ready_v;
  assign bus1.yk = yk_v;
  assign bus1.ak = ak_v;
  assign bus1.in_valid = in_valid_v;
  assign bus1.out_ready = out_ready_v;

  nn_cost_array #(.NB(NB), .NK(NK), .NSAMP(NSAMP), .ACCW(10), .DEADBAND(0)) dut0 (
    .CLK(clk), .INIT(init), .bus(bus0));
  nn_cost_array #(.NB(NB), .NK(NK), .NSAMP(NSAMP), .ACCW(8), .DEADBAND(3)) dut1 (
    .CLK(clk), .INIT(init), .bus(bus1));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUTs at the last rising edge
  logic        s_seen = 1'b0;
  logic        s_init, s_iv, s_or;
  logic [31:0] s_yk, s_ak;
  always @(posedge clk) begin
    s_seen <= 1'b1;
    s_init <= init;
    s_iv   <= in_valid_v;
    s_or   <= out_ready_v;
    s_yk   <= yk_v;
    s_ak   <= ak_v;
  end

  // Transaction-level model: a sample is accepted when idle, its result appears NK+1
  // cycles later, and is retired on out_ready; batch cost = min(total, 2^ACCW-1)
  int          db   [2] = '{0, 3};
  int          amax [2] = '{1023, 255};
  bit          m_busy, m_ov, m_cv;
  int          m_cyc, m_n;
  logic [31:0] m_eps  [2];
  logic [3:0]  m_sign [2];
  int          m_cost [2];
  int          m_acc  [2];
  logic [31:0] p_eps  [2];
  logic [3:0]  p_sign [2];
  int          p_sum  [2];

  function automatic void calc(input logic [31:0] y, input logic [31:0] a, input int dband,
                               output logic [31:0] e, output logic [3:0] s, output int sum);
    int yv, av, d;
    bit sg;
    e = '0; s = '0; sum = 0;
    for (int c = 0; c < NK; c++) begin
      yv = int'(y[c*8 +: 8]);
      av = int'(a[c*8 +: 8]);
      d  = (av > yv) ? av - yv : yv - av;
      sg = av > yv;
      if (dband != 0 && d < dband) begin d = 0; sg = 0; end
      e[c*8 +: 8] = d[7:0];
      s[c] = sg;
      sum += d;
    end
  endfunction

  task automatic model_step();
    if (s_init) begin
      m_busy = 0; m_ov = 0; m_cv = 0; m_cyc = 0; m_n = 0;
      for (int i = 0; i < 2; i++) begin
        m_eps[i] = '0; m_sign[i] = '0; m_cost[i] = 0; m_acc[i] = 0;
      end
    end else begin
      m_cv = 0;
      if (!m_busy) begin
        if (s_iv) begin
          m_busy = 1; m_cyc = 0;
          for (int i = 0; i < 2; i++) calc(s_yk, s_ak, db[i], p_eps[i], p_sign[i], p_sum[i]);
        end
      end else if (!m_ov) begin
        m_cyc++;
        if (m_cyc == NK + 1) begin
          m_ov = 1;
          for (int i = 0; i < 2; i++) begin m_eps[i] = p_eps[i]; m_sign[i] = p_sign[i]; end
        end
      end else if (s_or) begin
        m_ov = 0; m_busy = 0; m_n++;
        for (int i = 0; i < 2; i++) begin
          m_acc[i] = (m_acc[i] + p_sum[i] > amax[i]) ? amax[i] : m_acc[i] + p_sum[i];
        end
        if (m_n == NSAMP) begin
          m_cv = 1; m_n = 0;
          for (int i = 0; i < 2; i++) begin m_cost[i] = m_acc[i]; m_acc[i] = 0; end
        end
      end
    end
  endtask

  bit mon_en = 1'b1;
  initial forever begin
    @(negedge clk);
    if (s_seen && mon_en) begin
      model_step();
      chk("in_ready0",  bus0.in_ready,   !m_busy);
      chk("out_valid0", bus0.out_valid,  m_ov);
      chk("cost_vld0",  bus0.cost_valid, m_cv);
      chk("epsD0",      bus0.epsD,       m_eps[0]);
      chk("SIGN0",      bus0.SIGN,       m_sign[0]);
      chk("cost_sum0",  bus0.cost_sum,   m_cost[0]);
      chk("in_ready1",  bus1.in_ready,   !m_busy);
      chk("out_valid1", bus1.out_valid,  m_ov);
      chk("cost_vld1",  bus1.cost_valid, m_cv);
      chk("epsD1",      bus1.epsD,       m_eps[1]);
      chk("SIGN1",      bus1.SIGN,       m_sign[1]);
      chk("cost_sum1",  bus1.cost_sum,   m_cost[1]);
    end
  end

  localparam logic [31:0] Y2 = {8'd40, 8'd30, 8'd20, 8'd10};
  localparam logic [31:0] A2 = {8'd255, 8'd25, 8'd20, 8'd15};
  localparam logic [31:0] Y5 = {8'd10, 8'd10, 8'd10, 8'd10};
  localparam logic [31:0] A5 = {8'd10, 8'd7, 8'd13, 8'd12};

  task automatic accept_one(input logic [31:0] y, input logic [31:0] a);
    yk_v = y; ak_v = a; in_valid_v = 1'b1;
    @(negedge clk);
    in_valid_v = 1'b0;
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!bus0.out_valid && n < 20) begin @(negedge clk); n++; end
    chk("ov_timeout", bus0.out_valid, 1'b1);
  endtask

  task automatic retire();
    out_ready_v = 1'b1;
    @(negedge clk);
    out_ready_v = 1'b0;
  endtask

  initial begin
    // Reset held two edges
    @(negedge clk); @(negedge clk);
    chk("rst_epsD",  bus0.epsD, 0);
    chk("rst_SIGN",  bus0.SIGN, 0);
    chk("rst_cost",  bus0.cost_sum, 0);
    chk("rst_ov",    bus0.out_valid, 0);
    chk("rst_cv",    bus0.cost_valid, 0);
    chk("rst_ready", bus0.in_ready, 1);
    init = 1'b0;

    // Basic sample and latency
    accept_one(Y2, A2);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("lat_ov_e%0d", i), bus0.out_valid, (i == 5));
    end
    chk("t2_epsD", bus0.epsD, 32'hD7050005);
    chk("t2_SIGN", bus0.SIGN, 4'b1001);

    // Backpressure in DONE: outputs stable, new input ignored
    for (int i = 0; i < 6; i++) begin
      yk_v = $urandom; ak_v = $urandom; in_valid_v = 1'b1;
      @(negedge clk);
      chk("bp_epsD",  bus0.epsD, 32'hD7050005);
      chk("bp_ready", bus0.in_ready, 0);
    end
    in_valid_v = 1'b0;
    retire();
    chk("hs_ov",    bus0.out_valid, 0);
    chk("hs_ready", bus0.in_ready, 1);
    chk("hs_cv",    bus0.cost_valid, 0);

    // Second sample closes the batch
    accept_one(Y2, A2);
    wait_ov();
    retire();
    chk("t4_cv",   bus0.cost_valid, 1);
    chk("t4_sum0", bus0.cost_sum, 450);
    chk("t4_sum1", bus1.cost_sum, 255);
    @(negedge clk);
    chk("t4_cv_off", bus0.cost_valid, 0);

    // Deadband build vs plain build
    accept_one(Y5, A5);
    wait_ov();
    chk("t5_epsD1", bus1.epsD, 32'h00030300);
    chk("t5_SIGN1", bus1.SIGN, 4'b0010);
    chk("t5_epsD0", bus0.epsD, 32'h00030302);
    chk("t5_SIGN0", bus0.SIGN, 4'b0011);
    retire();

    // Reset in the middle of a scan (k=2), then a clean batch
    accept_one(Y2, A2);
    @(negedge clk); @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_ov", bus0.out_valid, 0);
    end
    accept_one(Y2, A2);
    wait_ov();
    retire();
    chk("t6_cv_first", bus0.cost_valid, 0);
    accept_one(Y2, A2);
    wait_ov();
    retire();
    chk("t6_cv",  bus0.cost_valid, 1);
    chk("t6_sum", bus0.cost_sum, 450);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] y, a;
      y = $urandom;
      a = $urandom;
      for (int c = 0; c < NK; c++) begin
        if ($urandom_range(3) == 0) a[c*8 +: 8] = y[c*8 +: 8];
        else if ($urandom_range(3) == 0) a[c*8 +: 8] = y[c*8 +: 8] + 8'($urandom_range(4));
      end
      yk_v = y; ak_v = a;
      in_valid_v  = $urandom_range(1);
      out_ready_v = ($urandom_range(2) != 0);
      init        = ($urandom_range(120) == 0);
      @(negedge clk);
    end
    init = 1'b0; in_valid_v = 1'b0; out_ready_v = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
